cache_ctrl_fsm: RTL and testbench
=================================

// Module: cache_ctrl_fsm
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate cache controller. Owns the tag/valid store.
//  Drives the program counter's Stall input while a miss refill or a memory write is outstanding.
//  Sequences block refills from main memory word by word, and strobes the cache data array.
//  Sits between the CPU pipeline (PC/stall, load/store) and the main-memory handshake.
// PARAMETERS
//  ADDR_W    10  word address width of cpu_addr / mem_addr
//  INDEX_W   5   cache line index bits (32 lines)
//  OFFSET_W  2   word-in-block bits (4 words per block)
//  TAG_W = ADDR_W-INDEX_W-OFFSET_W (localparam, not overridable)
// PORTS
//  CLK          in   1         clock, rising edge
//  RST          in   1         reset, asynchronous, active-low
//  cpu_addr     in   ADDR_W    word address of current load/store
//  cpu_rd       in   1         load request (level, held while Stall=1)
//  cpu_wr       in   1         store request (level, held while Stall=1)
//  Stall        out  1         hold PC/pipeline
//  hit          out  1         lookup hit in IDLE (combinational)
//  mem_rd_req   out  1         main-memory word read request
//  mem_wr_req   out  1         main-memory word write request
//  mem_addr     out  ADDR_W    main-memory word address
//  mem_ready    in   1         1-cycle ack: read word valid / write accepted
//  fill_en      out  1         write mem data word into cache data array
//  data_wr_en   out  1         write cpu store data into cache data array (write hit)
//  line_index   out  INDEX_W   data-array line for fill_en/data_wr_en/read
//  line_offset  out  OFFSET_W  data-array word for fill_en/data_wr_en/read
// BEHAVIOUR
//  Reset (RST=0, any state, mid-refill included): state=IDLE, all valid bits=0, refill count=0;
//   all outputs 0. An in-flight memory request is abandoned; a late mem_ready is ignored in IDLE.
//  States: IDLE, REFILL, WRITE.
//  IDLE: hit = valid[idx] & tag[idx]==cpu_tag. line_index/offset = cpu_addr fields.
//   cpu_wr (takes priority if cpu_rd also high): data_wr_en=hit; Stall=1; -> WRITE.
//   cpu_rd & hit: Stall=0, no transition (zero-wait read).
//   cpu_rd & !hit: Stall=1; latch block base address; refill count=0; -> REFILL.
//   Neither request: Stall=0.
//  REFILL: Stall=1, mem_rd_req=1, mem_addr={tag,idx,count}, line_offset=count.
//   mem_ready: fill_en=1 same cycle, count++. On count==2^OFFSET_W-1, at that edge
//   write tag, set valid, -> IDLE; the held cpu_rd then hits, so Stall drops one cycle later.
//   Valid is cleared on REFILL entry, so reset/abort never leaves a half-filled line valid.
//  WRITE: mem_wr_req=1, mem_addr=cpu_addr. Stall=!mem_ready (combinational), so the PC advances
//   on the mem_ready edge; -> IDLE on mem_ready. Store miss never allocates.
//  Read-miss latency: 2^OFFSET_W mem_ready acks + 1 cycle. Write latency: mem_ready + 0.
//  The refill counter wraps only via state exit; mem_ready outside REFILL/WRITE is ignored.
//  mem_rd_req/mem_wr_req are held high until mem_ready; they are never both high.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined: adds out ports hit_cnt[31:0] and miss_cnt[31:0], reset to 0.
//   hit_cnt increments once per IDLE cycle with (cpu_rd|cpu_wr)&hit&!Stall-exit
//   (read hit, or write-hit entry). miss_cnt increments once per IDLE->REFILL
//   or store-miss ->WRITE. Both saturate at 32'hFFFF_FFFF.
//  CACHE_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package cache_ctrl_pkg: state enum {IDLE,REFILL,WRITE}; ADDR_W/INDEX_W/OFFSET_W defaults;
//   helper functions to split address into tag/index/offset.
//  Sub-module cache_tag_store: 2^INDEX_W x (TAG_W+1) registers, async-reset valid bits,
//   combinational read port, one write port (set tag+valid / clear valid).
//  FSM, refill counter, and address mux live in cache_ctrl_fsm.
// TESTING
//  Cold read addr 10'h014, mem_ready every 3rd cycle -> 4 mem_rd_req words 0x014..0x017,
//   4 fill_en, Stall=1 throughout, then hit=1 & Stall=0; repeat read of 0x016 -> zero-wait hit.
//  Store hit 0x015 after fill -> data_wr_en=1 in IDLE, mem_wr_req until mem_ready,
//   Stall=0 on the ack cycle, back in IDLE.
//  Store miss 0x3F0 -> no data_wr_en, no fill, one memory write; subsequent read 0x3F0 misses.
//  Conflict: read 0x014 then 0x094 (same index) -> second refills, replaces tag; 0x014 misses again.
//  Reset asserted after 2nd refill word -> outputs 0, IDLE; re-read 0x014 misses (line not valid).
//  cpu_rd&cpu_wr both high -> handled as write; with CACHE_PERF_CNT_EN, check hit_cnt/miss_cnt totals.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cache_ctrl_pkg
// Shared types and helpers for the direct-mapped write-through cache
// controller: the controller state encoding, default address geometry and
// functions that split a word address into tag / index / offset fields.
// The helpers take the field widths as arguments so that they stay correct
// when the controller is built with non-default widths.
// ---------------------------------------------------------------------------
package cache_ctrl_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int INDEX_W_DEF  = 5;
    localparam int OFFSET_W_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Tag field: everything above index and offset.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int          index_w,
                                             input int          offset_w);
        return addr >> (index_w + offset_w);
    endfunction

    // Line index field.
    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int          index_w,
                                               input int          offset_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    // Word-in-block field.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int          offset_w);
        return addr & ((32'd1 << offset_w) - 32'd1);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// ---------------------------------------------------------------------------
// cache_tag_store
// Tag and valid storage for a direct-mapped cache: 2^INDEX_W entries of
// {valid, tag}. Valid bits are cleared by the asynchronous reset; tags are
// plain storage and only become meaningful once their valid bit is set.
// Ports:
//   CLK, RST        clock (rising edge), asynchronous active-low reset
//   rd_idx          combinational lookup index
//   rd_tag/rd_valid stored tag and valid bit at rd_idx
//   wr_en           perform a write this cycle
//   wr_set          1: write tag and set valid, 0: clear valid only
//   wr_idx/wr_tag   write index and tag
// ---------------------------------------------------------------------------
module cache_tag_store #(
    parameter int INDEX_W = 5,
    parameter int TAG_W   = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic               wr_set,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int LINES = 1 << INDEX_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_set;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && wr_set) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_tag   = tags[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// cache_ctrl_fsm
// Controller for a direct-mapped, write-through, no-write-allocate cache.
// Looks up the tag store in IDLE, refills a whole block word by word on a
// read miss, and forwards every store to main memory. Stall holds the CPU
// pipeline while a refill or memory write is outstanding.
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-low reset
//   cpu_addr, cpu_rd, cpu_wr CPU word address and load/store requests (level)
//   Stall                    hold PC / pipeline
//   hit                      lookup hit while IDLE
//   mem_rd_req, mem_wr_req   main-memory word read / write request
//   mem_addr                 main-memory word address
//   mem_ready                one-cycle memory ack
//   fill_en                  write memory word into the data array
//   data_wr_en               write CPU store data into the data array
//   line_index, line_offset  data-array line / word select
//   hit_cnt, miss_cnt        (only with CACHE_PERF_CNT_EN) saturating counters
// Build option: define CACHE_PERF_CNT_EN to add hit/miss performance counters.
// ---------------------------------------------------------------------------
module cache_ctrl_fsm
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic                cpu_rd,
    input  logic                cpu_wr,
    output logic                Stall,
    output logic                hit,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ready,
    output logic                fill_en,
    output logic                data_wr_en,
    output logic [INDEX_W-1:0]  line_index,
    output logic [OFFSET_W-1:0] line_offset
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    state_t state, state_nxt;

    logic [OFFSET_W-1:0] count;
    logic [TAG_W-1:0]    base_tag;
    logic [INDEX_W-1:0]  base_idx;

    logic [31:0] cpu_tag32, cpu_idx32, cpu_off32;
    logic [TAG_W-1:0]    cpu_tag;
    logic [INDEX_W-1:0]  cpu_idx;
    logic [OFFSET_W-1:0] cpu_off;
    logic                unused_addr_bits;

    logic [TAG_W-1:0]    st_tag;
    logic                st_valid;
    logic                lookup_hit;

    logic                ts_we, ts_set;
    logic [INDEX_W-1:0]  ts_idx;
    logic [TAG_W-1:0]    ts_tag;
    logic                latch_base;
    logic                count_inc;

    assign cpu_tag32 = addr_tag(32'(cpu_addr), INDEX_W, OFFSET_W);
    assign cpu_idx32 = addr_index(32'(cpu_addr), INDEX_W, OFFSET_W);
    assign cpu_off32 = addr_offset(32'(cpu_addr), OFFSET_W);
    assign cpu_tag   = cpu_tag32[TAG_W-1:0];
    assign cpu_idx   = cpu_idx32[INDEX_W-1:0];
    assign cpu_off   = cpu_off32[OFFSET_W-1:0];
    assign unused_addr_bits = ^{cpu_tag32[31:TAG_W], cpu_idx32[31:INDEX_W],
                                cpu_off32[31:OFFSET_W]};

    cache_tag_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_store (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (cpu_idx),
        .rd_tag   (st_tag),
        .rd_valid (st_valid),
        .wr_en    (ts_we),
        .wr_set   (ts_set),
        .wr_idx   (ts_idx),
        .wr_tag   (ts_tag)
    );

    assign lookup_hit = st_valid && (st_tag == cpu_tag);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            if (latch_base) begin
                count <= '0;
            end else if (count_inc) begin
                // Wraps back to zero on the last word, together with the exit.
                count <= count + 1'b1;
            end
        end
    end

    // Block base address; only meaningful while REFILL is active.
    always_ff @(posedge CLK) begin
        if (latch_base) begin
            base_tag <= cpu_tag;
            base_idx <= cpu_idx;
        end
    end

    // Outputs are forced low while reset is held so a held request cannot
    // leak a Stall or strobe out of the reset state.
    always_comb begin
        state_nxt   = state;
        Stall       = 1'b0;
        hit         = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = '0;
        fill_en     = 1'b0;
        data_wr_en  = 1'b0;
        line_index  = '0;
        line_offset = '0;
        ts_we       = 1'b0;
        ts_set      = 1'b0;
        ts_idx      = cpu_idx;
        ts_tag      = cpu_tag;
        latch_base  = 1'b0;
        count_inc   = 1'b0;
        if (RST) begin
            case (state)
                IDLE: begin
                    hit         = lookup_hit;
                    line_index  = cpu_idx;
                    line_offset = cpu_off;
                    if (cpu_wr) begin
                        data_wr_en = lookup_hit;
                        Stall      = 1'b1;
                        state_nxt  = WRITE;
                    end else if (cpu_rd && !lookup_hit) begin
                        Stall      = 1'b1;
                        latch_base = 1'b1;
                        // Invalidate now so an aborted refill never leaves a
                        // partially filled line marked valid.
                        ts_we      = 1'b1;
                        ts_set     = 1'b0;
                        state_nxt  = REFILL;
                    end
                end
                REFILL: begin
                    Stall       = 1'b1;
                    mem_rd_req  = 1'b1;
                    mem_addr    = {base_tag, base_idx, count};
                    line_index  = base_idx;
                    line_offset = count;
                    if (mem_ready) begin
                        fill_en   = 1'b1;
                        count_inc = 1'b1;
                        if (&count) begin
                            ts_we     = 1'b1;
                            ts_set    = 1'b1;
                            ts_idx    = base_idx;
                            ts_tag    = base_tag;
                            state_nxt = IDLE;
                        end
                    end
                end
                WRITE: begin
                    mem_wr_req  = 1'b1;
                    mem_addr    = cpu_addr;
                    line_index  = cpu_idx;
                    line_offset = cpu_off;
                    // Release the pipeline on the ack cycle so the PC moves on
                    // the same edge that returns us to IDLE.
                    Stall       = !mem_ready;
                    if (mem_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic req_idle;
    assign req_idle = (state == IDLE) && (cpu_rd || cpu_wr);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (req_idle) begin
            if (lookup_hit) begin
                hit_cnt <= sat_inc(hit_cnt);
            end else begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_cache_ctrl_fsm
// Directed bench for cache_ctrl_fsm: cold refill, zero-wait hit, store hit,
// store miss, index conflict, reset during refill, simultaneous rd/wr and,
// when CACHE_PERF_CNT_EN is defined, the performance counter totals.
// ---------------------------------------------------------------------------
module tb_cache_ctrl_fsm;

    logic       CLK = 1'b0;
    logic       RST;
    logic [9:0] cpu_addr;
    logic       cpu_rd, cpu_wr;
    logic       Stall, hit, mem_rd_req, mem_wr_req;
    logic [9:0] mem_addr;
    logic       mem_ready;
    logic       fill_en, data_wr_en;
    logic [4:0] line_index;
    logic [1:0] line_offset;
`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    cache_ctrl_fsm dut (
        .CLK         (CLK),
        .RST         (RST),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .Stall       (Stall),
        .hit         (hit),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .fill_en     (fill_en),
        .data_wr_en  (data_wr_en),
        .line_index  (line_index),
        .line_offset (line_offset)
`ifdef CACHE_PERF_CNT_EN
        ,
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one block refill (gap idle cycles before each ack) and reports
    // what it saw; the calling test judges the results.
    task automatic refill_words(input int gap, input logic [9:0] base,
                                output int fills, output int addr_bad,
                                output int stall_low);
        logic [9:0] exp_a;
        fills = 0; addr_bad = 0; stall_low = 0;
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k <= gap; k++) begin
                @(posedge CLK); #1;
                mem_ready = (k == gap);
                @(negedge CLK);
                exp_a = base + 10'(w);
                if (fill_en) fills++;
                if (!mem_rd_req || mem_addr !== exp_a || line_offset !== 2'(w))
                    addr_bad++;
                if (!Stall) stall_low++;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; cpu_addr = 10'h014; cpu_rd = 1'b1; cpu_wr = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checks++; if (Stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", Stall); end
        checks++; if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit got=%b exp=0", hit); end
        checks++; if ({mem_rd_req, mem_wr_req, fill_en, data_wr_en} !== 4'b0)
            begin failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_rd_req, mem_wr_req, fill_en, data_wr_en}); end
        checks++; if (line_index !== 5'd0 || mem_addr !== 10'd0)
            begin failures++; $display("FAIL reset_addr got idx=%0d mem=%h exp 0/0", line_index, mem_addr); end
        @(posedge CLK); #1;
        RST = 1'b1; cpu_rd = 1'b0; cpu_addr = 10'h000;
        @(negedge CLK);
        checks++; if (Stall !== 1'b0 || hit !== 1'b0)
            begin failures++; $display("FAIL idle_after_reset got stall=%b hit=%b exp 0/0", Stall, hit); end
    endtask

    task automatic test_cold_read();
        int fills, bad, stl;
        @(posedge CLK); #1;
        cpu_addr = 10'h014; cpu_rd = 1'b1;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || Stall !== 1'b1 || mem_rd_req !== 1'b0)
            begin failures++; $display("FAIL cold_miss got hit=%b stall=%b rdreq=%b exp 0/1/0", hit, Stall, mem_rd_req); end
        refill_words(2, 10'h014, fills, bad, stl);
        checks++; if (fills !== 4) begin failures++; $display("FAIL cold_fills got=%0d exp=4", fills); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL cold_words got=%0d bad cycles exp=0", bad); end
        checks++; if (stl !== 0) begin failures++; $display("FAIL cold_stall got=%0d low cycles exp=0", stl); end
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        @(negedge CLK);
        checks++; if (hit !== 1'b1 || Stall !== 1'b0 || mem_rd_req !== 1'b0)
            begin failures++; $display("FAIL cold_done got hit=%b stall=%b rdreq=%b exp 1/0/0", hit, Stall, mem_rd_req); end
        @(posedge CLK); #1;
        cpu_addr = 10'h016;
        @(negedge CLK);
        checks++; if (hit !== 1'b1 || Stall !== 1'b0 || line_offset !== 2'd2 || line_index !== 5'd5)
            begin failures++; $display("FAIL rehit_016 got hit=%b stall=%b off=%0d idx=%0d exp 1/0/2/5", hit, Stall, line_offset, line_index); end
        @(posedge CLK); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic test_store_hit();
        @(posedge CLK); #1;
        cpu_addr = 10'h015; cpu_wr = 1'b1;
        @(negedge CLK);
        checks++; if (data_wr_en !== 1'b1 || hit !== 1'b1 || Stall !== 1'b1 || mem_wr_req !== 1'b0)
            begin failures++; $display("FAIL st_hit_idle got dwe=%b hit=%b stall=%b wrreq=%b exp 1/1/1/0", data_wr_en, hit, Stall, mem_wr_req); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b1 || mem_addr !== 10'h015 || Stall !== 1'b1 || data_wr_en !== 1'b0)
            begin failures++; $display("FAIL st_hit_wait got wrreq=%b addr=%h stall=%b dwe=%b exp 1/015/1/0", mem_wr_req, mem_addr, Stall, data_wr_en); end
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b1 || Stall !== 1'b0)
            begin failures++; $display("FAIL st_hit_ack got wrreq=%b stall=%b exp 1/0", mem_wr_req, Stall); end
        @(posedge CLK); #1;
        mem_ready = 1'b0; cpu_wr = 1'b0;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b0 || Stall !== 1'b0 || hit !== 1'b1)
            begin failures++; $display("FAIL st_hit_back got wrreq=%b stall=%b hit=%b exp 0/0/1", mem_wr_req, Stall, hit); end
    endtask

    task automatic test_store_miss();
        int fills, bad, stl;
        @(posedge CLK); #1;
        cpu_addr = 10'h3F0; cpu_wr = 1'b1;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || data_wr_en !== 1'b0 || Stall !== 1'b1)
            begin failures++; $display("FAIL st_miss_idle got hit=%b dwe=%b stall=%b exp 0/0/1", hit, data_wr_en, Stall); end
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b1 || mem_addr !== 10'h3F0 || fill_en !== 1'b0 || mem_rd_req !== 1'b0 || Stall !== 1'b0)
            begin failures++; $display("FAIL st_miss_write got wrreq=%b addr=%h fill=%b rdreq=%b stall=%b exp 1/3f0/0/0/0", mem_wr_req, mem_addr, fill_en, mem_rd_req, Stall); end
        @(posedge CLK); #1;
        mem_ready = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b1;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || Stall !== 1'b1 || mem_wr_req !== 1'b0)
            begin failures++; $display("FAIL st_miss_noalloc got hit=%b stall=%b wrreq=%b exp 0/1/0", hit, Stall, mem_wr_req); end
        refill_words(0, 10'h3F0, fills, bad, stl);
        checks++; if (fills !== 4 || bad !== 0 || stl !== 0)
            begin failures++; $display("FAIL refill_3f0 got fills=%0d bad=%0d stall_low=%0d exp 4/0/0", fills, bad, stl); end
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        @(negedge CLK);
        checks++; if (hit !== 1'b1 || Stall !== 1'b0)
            begin failures++; $display("FAIL hit_3f0 got hit=%b stall=%b exp 1/0", hit, Stall); end
        @(posedge CLK); #1;
        cpu_rd = 1'b0;
    endtask

    // Ends with a read of 0x014 missing; the reset test continues that refill.
    task automatic test_conflict();
        int fills, bad, stl;
        @(posedge CLK); #1;
        cpu_addr = 10'h014; cpu_rd = 1'b1;
        @(negedge CLK);
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL conf_014_before got hit=%b exp=1", hit); end
        @(posedge CLK); #1;
        cpu_addr = 10'h094;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || Stall !== 1'b1 || line_index !== 5'd5)
            begin failures++; $display("FAIL conf_094_miss got hit=%b stall=%b idx=%0d exp 0/1/5", hit, Stall, line_index); end
        refill_words(1, 10'h094, fills, bad, stl);
        checks++; if (fills !== 4 || bad !== 0 || stl !== 0)
            begin failures++; $display("FAIL refill_094 got fills=%0d bad=%0d stall_low=%0d exp 4/0/0", fills, bad, stl); end
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        @(negedge CLK);
        checks++; if (hit !== 1'b1) begin failures++; $display("FAIL conf_094_hit got hit=%b exp=1", hit); end
        @(posedge CLK); #1;
        cpu_addr = 10'h014;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || Stall !== 1'b1)
            begin failures++; $display("FAIL conf_014_evicted got hit=%b stall=%b exp 0/1", hit, Stall); end
    endtask

    task automatic test_reset_mid_refill();
        int fills, bad, stl;
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (fill_en !== 1'b1 || mem_addr !== 10'h014)
            begin failures++; $display("FAIL abort_word0 got fill=%b addr=%h exp 1/014", fill_en, mem_addr); end
        @(posedge CLK); #1;
        @(negedge CLK);
        checks++; if (fill_en !== 1'b1 || mem_addr !== 10'h015)
            begin failures++; $display("FAIL abort_word1 got fill=%b addr=%h exp 1/015", fill_en, mem_addr); end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        checks++; if ({Stall, hit, mem_rd_req, mem_wr_req, fill_en, data_wr_en} !== 6'b0 || line_index !== 5'd0 || line_offset !== 2'd0)
            begin failures++; $display("FAIL abort_outputs got=%b idx=%0d off=%0d exp all 0", {Stall, hit, mem_rd_req, mem_wr_req, fill_en, data_wr_en}, line_index, line_offset); end
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1; mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (hit !== 1'b0 || Stall !== 1'b1 || fill_en !== 1'b0 || mem_rd_req !== 1'b0)
            begin failures++; $display("FAIL reread_014 got hit=%b stall=%b fill=%b rdreq=%b exp 0/1/0/0", hit, Stall, fill_en, mem_rd_req); end
        refill_words(1, 10'h014, fills, bad, stl);
        checks++; if (fills !== 4 || bad !== 0 || stl !== 0)
            begin failures++; $display("FAIL refill_after_reset got fills=%0d bad=%0d stall_low=%0d exp 4/0/0", fills, bad, stl); end
        @(posedge CLK); #1;
        mem_ready = 1'b0;
        @(negedge CLK);
        checks++; if (hit !== 1'b1 || Stall !== 1'b0)
            begin failures++; $display("FAIL hit_after_reset got hit=%b stall=%b exp 1/0", hit, Stall); end
        @(posedge CLK); #1;
        cpu_rd = 1'b0;
    endtask

    task automatic test_rd_wr_both();
        @(posedge CLK); #1;
        cpu_addr = 10'h014; cpu_rd = 1'b1; cpu_wr = 1'b1;
        @(negedge CLK);
        checks++; if (data_wr_en !== 1'b1 || Stall !== 1'b1 || mem_rd_req !== 1'b0)
            begin failures++; $display("FAIL rdwr_idle got dwe=%b stall=%b rdreq=%b exp 1/1/0", data_wr_en, Stall, mem_rd_req); end
        @(posedge CLK); #1;
        mem_ready = 1'b1;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0 || Stall !== 1'b0 || mem_addr !== 10'h014)
            begin failures++; $display("FAIL rdwr_write got wrreq=%b rdreq=%b stall=%b addr=%h exp 1/0/0/014", mem_wr_req, mem_rd_req, Stall, mem_addr); end
        @(posedge CLK); #1;
        mem_ready = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        @(negedge CLK);
        checks++; if (mem_wr_req !== 1'b0 || Stall !== 1'b0)
            begin failures++; $display("FAIL rdwr_back got wrreq=%b stall=%b exp 0/0", mem_wr_req, Stall); end
    endtask

`ifdef CACHE_PERF_CNT_EN
    // Since the last reset: one read miss (0x014), one hit on the held read
    // after its refill, one hit on the simultaneous rd/wr.
    task automatic test_perf_counts();
        @(negedge CLK);
        checks++; if (hit_cnt !== 32'd2) begin failures++; $display("FAIL hit_cnt got=%0d exp=2", hit_cnt); end
        checks++; if (miss_cnt !== 32'd1) begin failures++; $display("FAIL miss_cnt got=%0d exp=1", miss_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_cold_read();
        test_store_hit();
        test_store_miss();
        test_conflict();
        test_reset_mid_refill();
        test_rd_wr_both();
`ifdef CACHE_PERF_CNT_EN
        test_perf_counts();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
